// File: rtl/seq_pkg.sv
// Shared encodings for the exec_sequencer slice: FSM state codes, host
// command opcodes and halt-cause codes.
package seq_pkg;

  // FSM state codes (also driven out on state_o)
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_STEP = 2'b10;
  localparam logic [1:0] ST_HALT = 2'b11;

  // Host command opcodes on cmd_op
  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_RUN  = 2'b01;
  localparam logic [1:0] OP_STEP = 2'b10;
  localparam logic [1:0] OP_HALT = 2'b11;

  // Reason the core last entered HALT
  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_CMD  = 2'b01;
  localparam logic [1:0] CAUSE_BP   = 2'b10;
  localparam logic [1:0] CAUSE_LOOP = 2'b11;

endpackage

// File: rtl/exec_sequencer_sat_counter.sv
// sat_counter: up-counter with enable and asynchronous clear that sticks at
// its all-ones value instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q, count_d;

  // Next count: increment when enabled unless already saturated
  always_comb begin
    // NOTE: the default assignment first means every path writes count_d, so no latch is inferred.
    count_d = count_q;
    if (en && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  // Count register, cleared asynchronously
  always_ff @(posedge clk or posedge clr) begin
    // NOTE: non-blocking assignment keeps every flop sampling pre-edge values, independent of block order.
    if (clr) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/exec_sequencer.sv
// exec_sequencer: run/step/halt controller for the 4-bit core. Gates every
// PC/register update through exec_en, halts on host command, PC breakpoint or
// a jump-to-self, and counts executed instructions.
// Optional feature macro: BREAKPOINT_EN (breakpoint register, skip flag, bp_hit).
module exec_sequencer
  import seq_pkg::*;
#(
  parameter int BIT_WIDTH  = 4,
  parameter int INST_WIDTH = BIT_WIDTH + 4,
  parameter int CYC_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [BIT_WIDTH-1:0]  pc,
  input  logic [INST_WIDTH-1:0] inst,
  input  logic                  bp_wr,
  input  logic [BIT_WIDTH-1:0]  bp_addr_in,
  input  logic                  bp_arm_in,
  output logic                  exec_en,
  output logic [1:0]            state_o,
  output logic [1:0]            halt_cause,
  output logic                  step_done,
  output logic [CYC_WIDTH-1:0]  cyc_count
);

  logic [1:0] state_q, state_d;
  logic [1:0] cause_q, cause_d;
  logic       step_done_q, step_done_d;
  logic       exec_en_c;
  logic       cmd_acc;
  logic       hlt_cmd;
  logic       bp_hit;
  logic       self_loop;
  logic       unused_inst_bits;

  assign cmd_ready = (state_q != ST_STEP);
  assign cmd_acc   = cmd_valid & cmd_ready;
  assign hlt_cmd   = cmd_acc & (cmd_op == OP_HALT);

  // A jump (MSB set) whose target equals the current PC would spin forever
  assign self_loop = inst[INST_WIDTH-1] &
                     ({1'b0, inst[INST_WIDTH-6:0]} == pc);
  assign unused_inst_bits = ^inst[INST_WIDTH-2:INST_WIDTH-5];

`ifdef BREAKPOINT_EN
  logic [BIT_WIDTH-1:0] bp_addr_q, bp_addr_d;
  logic                 bp_arm_q, bp_arm_d;
  logic                 skip_q, skip_d;

  // Breakpoint load and skip-on-resume control
  always_comb begin
    bp_addr_d = bp_addr_q;
    bp_arm_d  = bp_arm_q;
    skip_d    = skip_q;
    if (bp_wr) begin
      bp_addr_d = bp_addr_in;
      bp_arm_d  = bp_arm_in;
    end
    // Resuming from HALT must execute the instruction that stopped us
    if ((state_q == ST_HALT) && cmd_acc && (cmd_op == OP_RUN)) begin
      skip_d = 1'b1;
    end else if (state_q == ST_RUN) begin
      skip_d = 1'b0;
    end
  end

  // Breakpoint registers
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: only control flops exist here and all of them get a reset value; nothing is left uninitialised.
    if (rst) begin
      bp_addr_q <= '0;
      bp_arm_q  <= 1'b0;
      skip_q    <= 1'b0;
    end else begin
      bp_addr_q <= bp_addr_d;
      bp_arm_q  <= bp_arm_d;
      skip_q    <= skip_d;
    end
  end

  // Compare uses the registered value, so a same-cycle bp_wr does not affect it
  assign bp_hit = bp_arm_q & (pc == bp_addr_q) & ~skip_q;
`else
  logic unused_bp_ports;
  assign unused_bp_ports = ^{bp_wr, bp_addr_in, bp_arm_in};
  assign bp_hit = 1'b0;
`endif

  // FSM next-state, halt cause and execute enable
  always_comb begin
    state_d     = state_q;
    cause_d     = cause_q;
    exec_en_c   = 1'b0;
    step_done_d = (state_q == ST_STEP);
    case (state_q)
      ST_IDLE: begin
        if (cmd_acc) begin
          case (cmd_op)
            OP_RUN:  state_d = ST_RUN;
            OP_STEP: state_d = ST_STEP;
            OP_HALT: begin
              state_d = ST_HALT;
              cause_d = CAUSE_CMD;
            end
            default: state_d = ST_IDLE;
          endcase
        end
      end
      ST_RUN: begin
        exec_en_c = ~(hlt_cmd | bp_hit | self_loop);
        if (hlt_cmd) begin
          state_d = ST_HALT;
          cause_d = CAUSE_CMD;
        end else if (bp_hit) begin
          state_d = ST_HALT;
          cause_d = CAUSE_BP;
        end else if (self_loop) begin
          state_d = ST_HALT;
          cause_d = CAUSE_LOOP;
        end
      end
      ST_STEP: begin
        // Single instruction regardless of breakpoint or self-loop
        exec_en_c = 1'b1;
        state_d   = ST_HALT;
        cause_d   = CAUSE_NONE;
      end
      default: begin // ST_HALT
        if (cmd_acc && (cmd_op == OP_RUN)) begin
          state_d = ST_RUN;
          cause_d = CAUSE_NONE;
        end else if (cmd_acc && (cmd_op == OP_STEP)) begin
          state_d = ST_STEP;
          cause_d = CAUSE_NONE;
        end
      end
    endcase
  end

  // FSM and registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cause_q     <= CAUSE_NONE;
      step_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cause_q     <= cause_d;
      step_done_q <= step_done_d;
    end
  end

  sat_counter #(
    .WIDTH (CYC_WIDTH)
  ) u_cyc_counter (
    .clk   (clk),
    .clr   (rst),
    .en    (exec_en_c),
    .count (cyc_count)
  );

  assign exec_en    = exec_en_c;
  assign state_o    = state_q;
  assign halt_cause = cause_q;
  assign step_done  = step_done_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer. A second instance with CYC_WIDTH = 4
// shares the stimulus and is used for the saturation check.
module tb_exec_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic [1:0] cmd_op;
  logic [3:0] pc;
  logic [7:0] inst;
  logic       bp_wr;
  logic [3:0] bp_addr_in;
  logic       bp_arm_in;

  logic        cmd_ready, exec_en, step_done;
  logic [1:0]  state_o, halt_cause;
  logic [15:0] cyc_count;

  logic        s_cmd_ready, s_exec_en, s_step_done;
  logic [1:0]  s_state_o, s_halt_cause;
  logic [3:0]  s_cyc_count;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  exec_sequencer dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .pc(pc), .inst(inst), .bp_wr(bp_wr),
    .bp_addr_in(bp_addr_in), .bp_arm_in(bp_arm_in), .exec_en(exec_en),
    .state_o(state_o), .halt_cause(halt_cause), .step_done(step_done),
    .cyc_count(cyc_count)
  );

  exec_sequencer #(.CYC_WIDTH(4)) dut_sat (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(s_cmd_ready),
    .cmd_op(cmd_op), .pc(pc), .inst(inst), .bp_wr(bp_wr),
    .bp_addr_in(bp_addr_in), .bp_arm_in(bp_arm_in), .exec_en(s_exec_en),
    .state_o(s_state_o), .halt_cause(s_halt_cause), .step_done(s_step_done),
    .cyc_count(s_cyc_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op);
    cmd_valid = 1'b1;
    cmd_op    = op;
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; pc = 4'd0; inst = 8'h00;
    bp_wr = 1'b0; bp_addr_in = 4'd0; bp_arm_in = 1'b0;
    #3;
    check("rst_state", state_o, 2'b00);
    check("rst_exec_en", exec_en, 1'b0);
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_cause", halt_cause, 2'b00);
    check("rst_step_done", step_done, 1'b0);
    check("rst_cyc", cyc_count, 16'd0);
    @(negedge clk);
    rst = 1'b0;

    // 1: RUN five instructions, then HALT command
    send(2'b01); #1;
    check("t1_idle_no_exec", exec_en, 1'b0);
    tick(); cmd_valid = 1'b0;
    check("t1_state_run", state_o, 2'b01);
    for (int i = 0; i < 5; i++) begin
      pc = 4'(i); #1;
      check("t1_exec", exec_en, 1'b1);
      tick();
    end
    pc = 4'd5; send(2'b11); #1;
    check("t1_halt_blocks_exec", exec_en, 1'b0);
    tick(); cmd_valid = 1'b0;
    check("t1_state_halt", state_o, 2'b11);
    check("t1_cause_cmd", halt_cause, 2'b01);
    check("t1_cyc5", cyc_count, 16'd5);

    // 2: breakpoint at PC 3, then resume through it
    bp_wr = 1'b1; bp_addr_in = 4'd3; bp_arm_in = 1'b1;
    tick(); bp_wr = 1'b0;
    pc = 4'd0; send(2'b01);
    tick(); cmd_valid = 1'b0;
    check("t2_state_run", state_o, 2'b01);
`ifdef BREAKPOINT_EN
    for (int i = 0; i < 3; i++) begin
      pc = 4'(i); #1;
      check("t2_exec", exec_en, 1'b1);
      tick();
    end
    pc = 4'd3; #1;
    check("t2_bp_blocks_exec", exec_en, 1'b0);
    tick();
    check("t2_state_halt", state_o, 2'b11);
    check("t2_cause_bp", halt_cause, 2'b10);
    check("t2_cyc8", cyc_count, 16'd8);
    send(2'b01);
    tick(); cmd_valid = 1'b0;
    check("t2_resume_cause_clr", halt_cause, 2'b00);
    pc = 4'd3; #1;
    check("t2_resume_exec_bp_pc", exec_en, 1'b1);
    tick();
    pc = 4'd4; #1;
    check("t2_resume_exec_next", exec_en, 1'b1);
    tick();
`else
    for (int i = 0; i < 5; i++) begin
      pc = 4'(i); #1;
      check("t2_nobp_exec", exec_en, 1'b1);
      tick();
      check("t2_nobp_state_run", state_o, 2'b01);
    end
`endif
    pc = 4'd5; send(2'b11);
    tick(); cmd_valid = 1'b0;
    check("t2_cause_cmd", halt_cause, 2'b01);
    check("t2_cyc10", cyc_count, 16'd10);

    // 3: single STEP from HALT
    send(2'b10);
    tick(); cmd_valid = 1'b0;
    check("t3_state_step", state_o, 2'b10);
    check("t3_exec", exec_en, 1'b1);
    check("t3_cmd_ready_low", cmd_ready, 1'b0);
    check("t3_step_done_early", step_done, 1'b0);
    tick();
    check("t3_state_halt", state_o, 2'b11);
    check("t3_step_done", step_done, 1'b1);
    check("t3_cause_none", halt_cause, 2'b00);
    check("t3_cyc11", cyc_count, 16'd11);
    check("t3_halt_no_exec", exec_en, 1'b0);
    tick();
    check("t3_step_done_pulse", step_done, 1'b0);

    // 4: jump-to-self at PC 6
    pc = 4'd6; inst = 8'h86; send(2'b01);
    tick(); cmd_valid = 1'b0;
    check("t4_state_run", state_o, 2'b01);
    check("t4_loop_blocks_exec", exec_en, 1'b0);
    tick();
    check("t4_state_halt", state_o, 2'b11);
    check("t4_cause_loop", halt_cause, 2'b11);
    check("t4_cyc_hold", cyc_count, 16'd11);
    inst = 8'h00;

    // 5: HALT command and breakpoint in the same cycle, then reset mid-RUN
    pc = 4'd2; send(2'b01);
    tick(); cmd_valid = 1'b0;
    check("t5_exec_pc2", exec_en, 1'b1);
    tick();
    pc = 4'd3; send(2'b11); #1;
    check("t5_exec_blocked", exec_en, 1'b0);
    tick(); cmd_valid = 1'b0;
    check("t5_cause_cmd_wins", halt_cause, 2'b01);
    check("t5_cyc12", cyc_count, 16'd12);
    pc = 4'd4; send(2'b01);
    tick(); cmd_valid = 1'b0;
    check("t5_run_exec", exec_en, 1'b1);
    #1 rst = 1'b1; #1;
    check("t5_rst_state", state_o, 2'b00);
    check("t5_rst_exec_en", exec_en, 1'b0);
    check("t5_rst_cmd_ready", cmd_ready, 1'b1);
    check("t5_rst_cause", halt_cause, 2'b00);
    check("t5_rst_step_done", step_done, 1'b0);
    check("t5_rst_cyc", cyc_count, 16'd0);
    check("t5_rst_sat_cyc", s_cyc_count, 4'd0);
    @(negedge clk);
    rst = 1'b0;

    // 6: saturation in the 4-bit counter; breakpoint was cleared by reset
    pc = 4'd3; send(2'b01);
    tick(); cmd_valid = 1'b0;
    check("t6_bp_cleared_exec", exec_en, 1'b1);
    tick();
    for (int n = 1; n < 20; n++) begin
      pc = pc + 4'd1;
      tick();
      if (n == 14) check("t6_sat_reach15", s_cyc_count, 4'd15);
    end
    check("t6_sat_hold15", s_cyc_count, 4'd15);
    check("t6_wide_cyc20", cyc_count, 16'd20);
    check("t6_sat_state_run", s_state_o, 2'b01);
    send(2'b11);
    tick(); cmd_valid = 1'b0;
    check("t6_sat_after_halt", s_cyc_count, 4'd15);
    check("t6_state_halt", state_o, 2'b11);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
